adder_sum_stage: RTL and testbench
==================================

Name: adder_sum_stage

Overview:
- Downstream consumer of the 47-bit prefix group-generate/propagate generator.
- Takes bitwise propagate p plus prefix P/G (span 1..i) and folds in carry-in.
- Produces sum, carry-out, signed overflow and zero flag.
- Registered output stage with valid/ready handshake and a one-entry skid buffer, so the combinational adder tree sits between two pipeline boundaries at full throughput.

Parameters:
- WIDTH, 47, operand width; bit vectors indexed [WIDTH:1], bit 1 = LSB.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream p/P/G/cin valid.
- in_ready  output  1  stage can accept this cycle.
- p  input  WIDTH  bitwise propagate a^b.
- P  input  WIDTH  prefix propagate, P[i] = p[1]&..&p[i].
- G  input  WIDTH  prefix generate, carry out of bits 1..i with cin=0.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- sum  output  WIDTH  result.
- cout  output  1  unsigned carry-out.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Carries: c[1] = cin; c[i] = G[i-1] | (P[i-1] & cin) for i = 2..WIDTH; c[WIDTH+1] = G[WIDTH] | (P[WIDTH] & cin).
- Result bits:
  - sum[i] = p[i] ^ c[i].
  - cout = c[WIDTH+1].
  - ovf = c[WIDTH] ^ c[WIDTH+1].
  - zero = ~|sum.
- Result computed combinationally from inputs and captured into registers; no output is driven combinationally from inputs.
- Storage: output register (out_valid plus data) and skid register (skid_valid plus data). Data width is WIDTH+3.
- in_ready = ~skid_valid, from a register only; no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Per-cycle update:
  - Pop with skid_valid: output <- skid; skid_valid <- 0. An accept in the same cycle is impossible because in_ready=0.
  - Accept when output empty or popping: output <- new result, out_valid <- 1.
  - Accept while output full and not popping: skid <- new result, skid_valid <- 1.
  - Pop with no accept and skid empty: out_valid <- 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result/cycle when out_ready is held high.
- Ordering is strictly FIFO; a result is never dropped or duplicated.
- Data registers change only on load; hold while out_valid & ~out_ready.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, skid_valid=0, in_ready=1.
  - sum=0, cout=0, ovf=0, zero=0.
  - In-flight results are discarded. First accept is allowed on the first clock after rst_n deasserts.
- Inputs are don't-care when in_valid=0. X on p/P/G must not propagate into valid flags.

Decomposition:
- Shared package adder_pkg:
  - ADD_WIDTH=47.
  - Typedef add_result_t {sum, cout, ovf, zero}.
  - Function for the carry/sum fold, reused by the bench scoreboard.
- One sub-module: skid_reg_slice, a generic WIDTH-data valid/ready register slice with skid entry. adder_sum_stage instantiates it with WIDTH+3 data bits beside the combinational fold.

Test Plan:
- Bench derives p/P/G from operands via the golden function.
- Carry ripple: a=0x7FFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> next cycle out_valid=1, sum=0, cout=1, ovf=0, zero=1.
- Signed overflow: a=0x3FFF_FFFF_FFFF, b=1, cin=0 -> sum=0x4000_0000_0000, cout=0, ovf=1, zero=0. Repeat with a=0, b=0, cin=1 -> sum=1, zero=0.
- Backpressure/skid: stream results R1,R2,R3 with out_ready=0 from cycle 1 -> R1 held on output, R2 in skid, in_ready=0 with R3 stalled. Raise out_ready -> R1, R2, R3 emerge in order on consecutive cycles, in_ready returns to 1.
- Full throughput: 1000 random back-to-back transfers, out_ready=1 -> one result per cycle, all match scoreboard, in_ready never deasserts.
- Reset mid-operation: skid full, assert rst_n=0 asynchronously between edges -> out_valid=0, in_ready=1, sum=0 immediately. After release, next accepted result appears alone, with no stale R1/R2.
- Random out_ready toggling (50%) with random in_valid -> no loss or duplication. Data stable whenever out_valid & ~out_ready.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder sum stage: operand width, the packed
// result record, and the carry/sum fold built from prefix P/G terms.
package adder_pkg;

  localparam int ADD_WIDTH = 47;

  // One adder result; packed so it can travel through a plain data register.
  typedef struct packed {
    logic [ADD_WIDTH:1] sum;
    logic               cout;
    logic               ovf;
    logic               zero;
  } add_result_t;

  // Fold carry-in into the prefix terms and form sum, carry-out, signed
  // overflow and the zero flag. Bit 1 is the LSB.
  function automatic add_result_t add_fold(
    input logic [ADD_WIDTH:1] p,
    input logic [ADD_WIDTH:1] P,
    input logic [ADD_WIDTH:1] G,
    input logic               cin
  );
    logic [ADD_WIDTH+1:1] c;
    add_result_t          r;
    c[1] = cin;
    for (int i = 2; i <= ADD_WIDTH + 1; i++) begin
      c[i] = G[i-1] | (P[i-1] & cin);
    end
    r.sum  = p ^ c[ADD_WIDTH:1];
    r.cout = c[ADD_WIDTH+1];
    r.ovf  = c[ADD_WIDTH] ^ c[ADD_WIDTH+1];
    r.zero = ~|r.sum;
    return r;
  endfunction

endpackage

// File: rtl/skid_reg_slice.sv
// Generic valid/ready register slice with a one-entry skid buffer.
// in_ready depends only on the skid register, so there is no combinational
// path from out_ready back upstream.
module skid_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             accept_s;
  logic             pop_s;

  assign in_ready  = ~skid_valid_r;
  assign accept_s  = in_valid & ~skid_valid_r;
  assign pop_s     = out_valid_r & out_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Output and skid registers: refill from skid first, otherwise load new
  // data into the output when it frees up, else park it in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
    end else begin
      if (pop_s && skid_valid_r) begin
        out_data_r   <= skid_data_r;
        skid_valid_r <= 1'b0;
      end else if (accept_s && (!out_valid_r || pop_s)) begin
        out_data_r  <= in_data;
        out_valid_r <= 1'b1;
      end else if (accept_s) begin
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: rtl/adder_sum_stage.sv
// Final adder stage: combinational carry/sum fold from prefix P/G terms,
// registered through a skid slice so every output comes from a flop.
module adder_sum_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] p,
  input  logic [WIDTH:1] P,
  input  logic [WIDTH:1] G,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:1] sum,
  output logic           cout,
  output logic           ovf,
  output logic           zero
);

  add_result_t          result_s;
  logic [WIDTH+2:0]     out_data_s;

  assign result_s = add_fold(p, P, G, cin);

  skid_reg_slice #(
    .WIDTH (WIDTH + 3)
  ) u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (result_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  assign {sum, cout, ovf, zero} = out_data_s;

endmodule

// File: tb/tb_adder_sum_stage.sv
// Self-checking bench for adder_sum_stage: operands are turned into p/P/G
// with plain arithmetic, expected results come from integer addition, and a
// queue models the in-flight results between accept and pop.
module tb_adder_sum_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [46:0] p_i = '0, pp_i = '0, gg_i = '0;
  logic        cin_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [46:0] sum;
  logic        cout, ovf, zero;

  logic [46:0] a_cur = '0, b_cur = '0;

  int checks = 0;
  int errors = 0;

  logic [49:0] q[$];
  logic        hold_prev = 1'b0;
  logic [49:0] prev_data = '0;

  always #5 clk = ~clk;

  adder_sum_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p_i),
    .P         (pp_i),
    .G         (gg_i),
    .cin       (cin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {sum, cout, ovf, zero} from plain integer addition.
  function automatic logic [49:0] model(input logic [46:0] a, input logic [46:0] b, input logic c);
    logic [47:0] s;
    logic [46:0] sm;
    logic        v;
    s  = {1'b0, a} + {1'b0, b} + {47'd0, c};
    sm = s[46:0];
    v  = (a[46] == b[46]) && (sm[46] != a[46]);
    return {sm, s[47], v, (sm == 47'd0)};
  endfunction

  // p = a^b; P[i] = all propagates up to i; G[i] = carry out of the low i+1 bits.
  task automatic drive(input logic [46:0] a, input logic [46:0] b, input logic c, input logic v);
    logic [47:0] mask, s, pw;
    logic [46:0] pp, gg;
    pw = {1'b0, a ^ b};
    for (int i = 0; i < 47; i++) begin
      mask  = (48'd1 << (i + 1)) - 48'd1;
      s     = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      gg[i] = s[i+1];
      pp[i] = ((pw & mask) == mask);
    end
    a_cur = a; b_cur = b;
    p_i = a ^ b; pp_i = pp; gg_i = gg; cin_i = c; in_valid = v;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [46:0] rnd47;
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[46:0];
  endfunction

  // Scoreboard: sampled mid-cycle, checks flags, data and hold stability
  // against the queue of accepted-but-not-popped results.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      check("out_valid_vs_model", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
      check("in_ready_vs_model", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
      if (out_valid && q.size() > 0)
        check("data_vs_model", {14'd0, sum, cout, ovf, zero}, {14'd0, q[0]});
      if (hold_prev)
        check("hold_stable", {14'd0, sum, cout, ovf, zero}, {14'd0, prev_data});
      hold_prev = out_valid & ~out_ready;
      prev_data = {sum, cout, ovf, zero};
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(a_cur, b_cur, cin_i));
    end
  end

  logic [49:0] r1, r2, r3, r4;

  initial begin
    // Pin the model with hand-computed results.
    check("model_ripple", {14'd0, model(47'h7FFF_FFFF_FFFF, 47'd1, 1'b0)}, {14'd0, 47'd0, 1'b1, 1'b0, 1'b1});
    check("model_ovf_pos", {14'd0, model(47'h3FFF_FFFF_FFFF, 47'd1, 1'b0)}, {14'd0, 47'h4000_0000_0000, 1'b0, 1'b1, 1'b0});
    check("model_cin", {14'd0, model(47'd0, 47'd0, 1'b1)}, {14'd0, 47'd1, 1'b0, 1'b0, 1'b0});
    check("model_ovf_neg", {14'd0, model(47'h4000_0000_0000, 47'h4000_0000_0000, 1'b0)}, {14'd0, 47'd0, 1'b1, 1'b1, 1'b1});

    // Reset state.
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_data", {14'd0, sum, cout, ovf, zero}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Carry ripple through all bits.
    drive(47'h7FFF_FFFF_FFFF, 47'd1, 1'b0, 1'b1);
    step;
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    check("ripple_valid", {63'd0, out_valid}, 64'd1);
    check("ripple_res", {14'd0, sum, cout, ovf, zero}, {14'd0, 47'd0, 1'b1, 1'b0, 1'b1});

    // Signed overflow, then carry-in only.
    drive(47'h3FFF_FFFF_FFFF, 47'd1, 1'b0, 1'b1);
    step;
    check("ovf_res", {14'd0, sum, cout, ovf, zero}, {14'd0, 47'h4000_0000_0000, 1'b0, 1'b1, 1'b0});
    drive(47'd0, 47'd0, 1'b1, 1'b1);
    step;
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    check("cin_res", {14'd0, sum, cout, ovf, zero}, {14'd0, 47'd1, 1'b0, 1'b0, 1'b0});
    step;
    check("idle_empty", {63'd0, out_valid}, 64'd0);

    // Backpressure: R1 on output, R2 in skid, R3 stalled.
    r1 = model(47'd5, 47'd6, 1'b0);
    r2 = model(47'd100, 47'd200, 1'b1);
    r3 = model(47'h7FFF_FFFF_FFFF, 47'h7FFF_FFFF_FFFF, 1'b0);
    out_ready = 1'b0;
    drive(47'd5, 47'd6, 1'b0, 1'b1);
    step;
    drive(47'd100, 47'd200, 1'b1, 1'b1);
    step;
    drive(47'h7FFF_FFFF_FFFF, 47'h7FFF_FFFF_FFFF, 1'b0, 1'b1);
    step;
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_r1_held", {14'd0, sum, cout, ovf, zero}, {14'd0, r1});
    step;
    check("bp_r1_still", {14'd0, sum, cout, ovf, zero}, {14'd0, r1});
    out_ready = 1'b1;
    step;
    check("bp_r2_out", {14'd0, sum, cout, ovf, zero}, {14'd0, r2});
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    step;
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    check("bp_r3_out", {14'd0, sum, cout, ovf, zero}, {14'd0, r3});
    step;
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Full throughput.
    for (int n = 0; n < 1000; n++) begin
      drive(rnd47(), rnd47(), 1'($urandom_range(0, 1)), 1'b1);
      step;
      check("tput_valid", {63'd0, out_valid}, 64'd1);
      check("tput_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    step;

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    drive(47'd11, 47'd22, 1'b0, 1'b1);
    step;
    drive(47'd33, 47'd44, 1'b0, 1'b1);
    step;
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_sum", {17'd0, sum}, 64'd0);
    step;
    rst_n = 1'b1;
    out_ready = 1'b1;
    r4 = model(47'd1000, 47'd2345, 1'b1);
    drive(47'd1000, 47'd2345, 1'b1, 1'b1);
    step;
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_res", {14'd0, sum, cout, ovf, zero}, {14'd0, r4});
    step;
    check("post_rst_alone", {63'd0, out_valid}, 64'd0);

    // Random valid / ready toggling.
    for (int n = 0; n < 600; n++) begin
      drive(rnd47(), rnd47(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      step;
    end
    drive(47'd0, 47'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (4) step;
    @(negedge clk); #1;
    check("final_queue_empty", {32'd0, 32'(q.size())}, 64'd0);
    check("final_out_valid", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
